// File: rtl/meteor_pkg.sv
// Shared types and constants for the meteor-field gameplay blocks.
package meteor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  // Feedback taps for x^16+x^14+x^13+x^11: bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          DEFAULT_COLS = 8;
  localparam int          DEFAULT_ROWS = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/meteor_field_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock regardless of game state.
module lfsr16
  import meteor_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk_in,
  input  logic        reset_n,
  output logic [15:0] q
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/meteor_field.sv
// Meteor field gameplay core: turns game_clk rises into ticks, scrolls the grid,
// spawns meteors from an LFSR, detects the player collision and counts dodges.
module meteor_field
  import meteor_pkg::*;
#(
  parameter int          COLS       = DEFAULT_COLS,
  parameter int          ROWS       = DEFAULT_ROWS,
  parameter logic [7:0]  SPAWN_RATE = 8'd96,
  parameter logic [15:0] SEED       = DEFAULT_SEED
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic                      game_clk,
  input  logic                      start,
  input  logic [$clog2(COLS)-1:0]   player_col,
  output logic [ROWS*COLS-1:0]      field,
  output logic [15:0]               score,
  output logic                      game_over,
  output logic                      tick_o
);

  localparam int CW = $clog2(COLS);

  state_t                 r_state;
  logic [ROWS*COLS-1:0]   r_field;
  logic [15:0]            r_score;
  logic                   r_gclk_q;
  logic                   r_tick_o;

  logic                   w_tick;
  logic [15:0]            w_lfsr;
  logic [CW-1:0]          w_spawn_col;
  logic [COLS-1:0]        w_spawn_row;
  logic [COLS-1:0]        w_entry_row;
  logic [COLS-1:0]        w_exit_row;
  logic                   w_hit;
  logic [ROWS*COLS-1:0]   w_field_shift;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .q       (w_lfsr)
  );

  assign w_tick = game_clk & ~r_gclk_q;

  // COLS is a power of two, so the modulo is just the low column bits of the LFSR
  assign w_spawn_col = CW'(w_lfsr[7:0] % 8'(COLS));
  assign w_spawn_row = (w_lfsr[15:8] < SPAWN_RATE) ? (COLS'(1) << w_spawn_col) : '0;

  assign w_entry_row   = r_field[(ROWS-2)*COLS +: COLS];
  assign w_exit_row    = r_field[(ROWS-1)*COLS +: COLS];
  assign w_hit         = w_entry_row[player_col];
  assign w_field_shift = {r_field[(ROWS-1)*COLS-1:0], w_spawn_row};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_field  <= '0;
      r_score  <= '0;
      r_gclk_q <= 1'b0;
      r_tick_o <= 1'b0;
    end else begin
      r_gclk_q <= game_clk;
      r_tick_o <= w_tick;
      case (r_state)
        IDLE: begin
          r_field <= '0;
          if (start) begin
            r_score <= '0;
            r_state <= PLAY;
          end
        end
        PLAY: begin
          if (w_tick) begin
            r_field <= w_field_shift;
            // Only the entry into the player row can collide; a meteor leaving it is a dodge
            if (w_hit) begin
              r_state <= GAME_OVER;
            end else if ((|w_exit_row) && (r_score != 16'hFFFF)) begin
              r_score <= r_score + 16'd1;
            end
          end
        end
        GAME_OVER: begin
          if (start) begin
            r_field <= '0;
            r_score <= '0;
            r_state <= PLAY;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign field     = r_field;
  assign score     = r_score;
  assign game_over = (r_state == GAME_OVER);
  assign tick_o    = r_tick_o;

endmodule

// File: tb/tb_meteor_field.sv
// Randomized scoreboard bench for meteor_field: a row-array game model predicts the
// field/score/game_over shown on every tick_o pulse; a monitor compares them.
module tb_meteor_field;

  localparam int          COLS       = 8;
  localparam int          ROWS       = 8;
  localparam logic [7:0]  SPAWN_RATE = 8'd96;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic                   clk_in;
  logic                   reset_n;
  logic                   game_clk;
  logic                   start;
  logic [2:0]             player_col;
  logic [ROWS*COLS-1:0]   field;
  logic [15:0]            score;
  logic                   game_over;
  logic                   tick_o;

  meteor_field #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .SPAWN_RATE (SPAWN_RATE),
    .SEED       (SEED)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .game_clk   (game_clk),
    .start      (start),
    .player_col (player_col),
    .field      (field),
    .score      (score),
    .game_over  (game_over),
    .tick_o     (tick_o)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [63:0] fld;
    int          scr;
    bit          go;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tick_count = 0;

  // Game model: rows as an array, plain integer score, mode 0=idle 1=playing 2=over
  logic [7:0]  m_rows [ROWS];
  int          m_score;
  int          m_mode;
  logic [15:0] m_lfsr;
  bit          m_prev_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] flatten();
    logic [63:0] f = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        f[r*COLS + c] = m_rows[r][c];
    return f;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
    m_score = 0;
  endtask

  task automatic model_step(input bit g, input bit s, input logic [2:0] pc);
    bit        tk;
    bit        hit;
    bit        dodged;
    logic [7:0] spawn;
    exp_t      e;
    tk = g && !m_prev_g;
    if (m_mode == 0) begin
      if (s) begin
        model_clear();
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (tk) begin
        spawn  = (m_lfsr[15:8] < SPAWN_RATE) ? (8'd1 << m_lfsr[2:0]) : 8'd0;
        hit    = m_rows[ROWS-2][pc];
        dodged = (m_rows[ROWS-1] != 8'd0);
        for (int r = ROWS-1; r > 0; r--) m_rows[r] = m_rows[r-1];
        m_rows[0] = spawn;
        if (hit) m_mode = 2;
        else if (dodged && m_score < 65535) m_score++;
      end
    end else begin
      if (s) begin
        model_clear();
        m_mode = 1;
      end
    end
    if (tk) begin
      e.fld = flatten();
      e.scr = m_score;
      e.go  = (m_mode == 2);
      exp_q.push_back(e);
    end
    m_lfsr   = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_prev_g = g;
  endtask

  task automatic drive(input bit g, input bit s, input logic [2:0] pc);
    @(negedge clk_in);
    reset_n    = 1'b1;
    game_clk   = g;
    start      = s;
    player_col = pc;
    model_step(g, s, pc);
  endtask

  function automatic bit gclk_at(input int cyc);
    return ((cyc / 4) % 2) == 0;
  endfunction

  // Monitor: every tick_o pulse must match the oldest predicted tick
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (reset_n && tick_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick_unexpected actual tick_o=1 required tick_o=0");
        end else begin
          e = exp_q.pop_front();
          tick_count++;
          check("tick_field", field, e.fld);
          check("tick_score", 64'(score), 64'(e.scr));
          check("tick_game_over", 64'(game_over), 64'(e.go));
          $display("tick %0d field %h score %0d game_over %0d", tick_count, field, score, game_over);
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    game_clk   = 1'b0;
    start      = 1'b0;
    player_col = 3'd0;
    model_clear();
    m_mode   = 0;
    m_lfsr   = SEED;
    m_prev_g = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      game_clk = ~game_clk;
      check("rst_field", field, 64'd0);
      check("rst_score", 64'(score), 64'd0);
      check("rst_game_over", 64'(game_over), 64'd0);
      check("rst_tick_o", 64'(tick_o), 64'd0);
      check("rst_lfsr", 64'(dut.u_lfsr.q), 64'hACE1);
    end

    // Release with game_clk high: the resulting tick must leave the game idle
    for (int cyc = 0; cyc < 24; cyc++) begin
      drive(gclk_at(cyc), 1'b0, 3'($urandom_range(0, 7)));
      if (cyc == 20) begin
        check("idle_field", field, 64'd0);
        check("idle_game_over", 64'(game_over), 64'd0);
      end
    end

    // Start coincides with a game_clk rise: game starts, no shift applied
    drive(gclk_at(24), 1'b1, 3'd0);
    @(negedge clk_in);
    check("start_tick_field", field, 64'd0);
    check("start_tick_game_over", 64'(game_over), 64'd0);
    model_step(gclk_at(25), 1'b0, player_col);
    start = 1'b0;

    for (int cyc = 26; cyc < 4000; cyc++) begin
      drive(gclk_at(cyc), ($urandom_range(0, 59) == 0), 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 3'd0);
    check("pending_ticks", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
